sprite_box_datapath: RTL and testbench
======================================

Name: sprite_box_datapath

Overview:
- Parametrised successor of the enemy box-draw datapath.
- Latches an anchor (x, y) and colour, then on a start pulse sweeps a SPRITE_W x SPRITE_H box one pixel per step.
- Emits VGA-adapter-style pixel writes (x_out, y_out, c_out, plot) with a busy/done handshake for the enemy/player control FSMs.
- Pixel pacing is gated by step_en, driven from the rate divider or tied high.

Parameters:
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- C_W, 3, colour width.
- SPRITE_W, 4, box width in pixels (1..2^X_W).
- SPRITE_H, 4, box height in pixels (1..2^Y_W).
- SCREEN_W, 160, visible width; used only with CLIP_EN.
- SCREEN_H, 120, visible height; used only with CLIP_EN.

Ports:
- clock, in, 1, system clock; all state on rising edge.
- resetn, in, 1, asynchronous active-low reset.
- load_x, in, 1, capture x_in into anchor X register (IDLE only).
- load_y, in, 1, capture y_in into anchor Y register (IDLE only).
- load_colour, in, 1, capture c_in into colour register (IDLE only).
- x_in, in, X_W, anchor x.
- y_in, in, Y_W, anchor y.
- c_in, in, C_W, colour.
- start, in, 1, begin a box sweep.
- step_en, in, 1, advance one pixel when high during DRAW.
- x_out, out, X_W, pixel x = anchor X + col.
- y_out, out, Y_W, pixel y = anchor Y + row.
- c_out, out, C_W, latched colour.
- plot, out, 1, pixel write strobe.
- busy, out, 1, high in DRAW.
- done, out, 1, one-cycle pulse after the last pixel.

Behaviour:
- Reset (async, resetn=0): state=IDLE; X, Y, colour, col, row = 0; all outputs 0. Takes effect immediately, including mid-sweep; no partial-sweep resume.
- States:
  - IDLE: busy=0, plot=0.
  - DRAW: busy=1.
  - DONE: single cycle, done=1, busy=0; then IDLE.
- Loads: honoured in IDLE and DONE only; ignored in DRAW.
- IDLE->DRAW on start=1. A load asserted on the same edge as start is captured and used by the sweep; col=row=0 at DRAW entry.
- start while in DRAW or DONE: ignored.
- In DRAW, outputs are combinational from registers: x_out=X+col, y_out=Y+row, c_out=colour. plot = step_en (pixel written on the edge where step_en=1).
- Counter advance on step_en=1: col increments; at col=SPRITE_W-1, col->0 and row increments.
- At col=SPRITE_W-1 and row=SPRITE_H-1 with step_en=1: last pixel plotted, next state DONE, col=row=0.
- step_en=0 in DRAW: hold counters, plot=0, busy stays 1.
- Latency: with step_en tied 1, first pixel on the cycle after start; done exactly SPRITE_W*SPRITE_H+1 cycles after the start edge.
- Arithmetic: additions truncated to X_W/Y_W, so coordinates wrap modulo 2^X_W and 2^Y_W. Counter widths are clog2 of the sprite dimensions (minimum 1).
- Outside DRAW: x_out, y_out, c_out present X, Y, colour (col=row=0).

Optional Feature:
- Macro: SPRITE_CLIP_EN.
- Defined: in DRAW, the pixel is clipped when the unwrapped X+col >= SCREEN_W or Y+row >= SCREEN_H, computed with one extra bit. A clipped pixel has plot=0 but still consumes its step, so sweep length and done timing are unchanged.
- Undefined: no clipping; plot follows step_en, and coordinates wrap.

Test Plan:
- Reset then load x_in=10, y_in=20, c_in=3'b101, start with step_en=1 -> 16 plots at (10..13, 20..23) in row-major order; c_out=5; done pulses at cycle 17; busy is low afterwards.
- step_en toggling 1/0 during a sweep -> plot only on step_en=1 cycles; 16 plots total; done is delayed accordingly; counters hold while step_en=0.
- Load x_in=50 plus a second start mid-sweep -> ignored; the sweep completes at the original anchor; the new load is accepted after done.
- resetn pulsed low at pixel 7 -> immediately busy=0, plot=0, outputs 0; IDLE afterwards; the next start sweeps from pixel 0.
- Anchor x_in=254 with X_W=8, no macro -> x_out sequence 254, 255, 0, 1 per row.
- SPRITE_CLIP_EN, anchor (158, 118), SCREEN 160x120 -> plot only at (158..159, 118..119), 4 plots; done still at cycle 17.

Source files
------------

// File: rtl/sprite_box_datapath.sv
// Box-sweep pixel datapath: latches an anchor and colour, then writes a SPRITE_W x SPRITE_H box one pixel per step_en.
// Optional screen clipping is enabled by defining SPRITE_CLIP_EN.
module sprite_box_datapath #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int C_W      = 3,
   parameter int SPRITE_W = 4,
   parameter int SPRITE_H = 4,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic           clock,
   input  logic           resetn,
   input  logic           load_x,
   input  logic           load_y,
   input  logic           load_colour,
   input  logic [X_W-1:0] x_in,
   input  logic [Y_W-1:0] y_in,
   input  logic [C_W-1:0] c_in,
   input  logic           start,
   input  logic           step_en,
   output logic [X_W-1:0] x_out,
   output logic [Y_W-1:0] y_out,
   output logic [C_W-1:0] c_out,
   output logic           plot,
   output logic           busy,
   output logic           done
);

   localparam int CW_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int RW_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam logic [CW_W-1:0] COL_LAST = CW_W'(SPRITE_W - 1);
   localparam logic [RW_W-1:0] ROW_LAST = RW_W'(SPRITE_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [X_W-1:0]  x_q, x_d;
   logic [Y_W-1:0]  y_q, y_d;
   logic [C_W-1:0]  colour_q, colour_d;
   logic [CW_W-1:0] col_q, col_d;
   logic [RW_W-1:0] row_q, row_d;
   logic            load_ok;
   logic            visible;

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      col_d    = col_q;
      row_d    = row_q;
      // Anchor registers are frozen for the whole sweep
      load_ok  = (state_q != S_DRAW);
      if (load_ok && load_x)      x_d      = x_in;
      if (load_ok && load_y)      y_d      = y_in;
      if (load_ok && load_colour) colour_d = c_in;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_DRAW;
               col_d   = '0;
               row_d   = '0;
            end
         end
         S_DRAW: begin
            if (step_en) begin
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  if (row_q == ROW_LAST) begin
                     row_d   = '0;
                     state_d = S_DONE;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         col_q    <= '0;
         row_q    <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         col_q    <= col_d;
         row_q    <= row_d;
      end
   end

`ifdef SPRITE_CLIP_EN
   logic [X_W:0] x_sum;
   logic [Y_W:0] y_sum;

   // One extra bit keeps the unwrapped coordinate for the screen-edge test
   always_comb begin
      x_sum   = {1'b0, x_q} + (X_W+1)'(col_q);
      y_sum   = {1'b0, y_q} + (Y_W+1)'(row_q);
      visible = (x_sum < (X_W+1)'(SCREEN_W)) && (y_sum < (Y_W+1)'(SCREEN_H));
      x_out   = x_sum[X_W-1:0];
      y_out   = y_sum[Y_W-1:0];
   end
`else
   always_comb begin
      visible = 1'b1;
      x_out   = x_q + X_W'(col_q);
      y_out   = y_q + Y_W'(row_q);
   end
`endif

   assign c_out = colour_q;
   assign busy  = (state_q == S_DRAW);
   assign done  = (state_q == S_DONE);
   assign plot  = busy && step_en && visible;

endmodule

// File: tb/tb_sprite_box_datapath.sv
// Bench for sprite_box_datapath: table of sweep scenarios checked against a pixel model and scoreboard,
// plus hand-written mid-sweep reset sequence.
module tb_sprite_box_datapath;

   logic       clock = 1'b0;
   logic       resetn;
   logic       load_x, load_y, load_colour;
   logic [7:0] x_in;
   logic [6:0] y_in;
   logic [2:0] c_in;
   logic       start, step_en;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] c_out;
   logic       plot, busy, done;

   sprite_box_datapath dut (
      .clock(clock), .resetn(resetn),
      .load_x(load_x), .load_y(load_y), .load_colour(load_colour),
      .x_in(x_in), .y_in(y_in), .c_in(c_in),
      .start(start), .step_en(step_en),
      .x_out(x_out), .y_out(y_out), .c_out(c_out),
      .plot(plot), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   // mode: 0 step_en tied high, 1 alternating, 2 random
   // ld:   0 load with start, 1 load a cycle before start, 2 start only
   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      int         mode;
      int         ld;
      bit         inject;
   } vec_t;

   pix_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   mx = 0, my = 0, mc = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit vis(input int ux, input int uy);
`ifdef SPRITE_CLIP_EN
      return (ux < 160) && (uy < 120);
`else
      return 1'b1;
`endif
   endfunction

   task automatic set_loads(input bit v);
      load_x = v;
      load_y = v;
      load_colour = v;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_plot"}, plot, 0);
      chk({tag, "_x"}, x_out, mx);
      chk({tag, "_y"}, y_out, my);
      chk({tag, "_c"}, c_out, mc);
   endtask

   // Per draw cycle: compare live outputs against the model and pop the scoreboard on plot
   task automatic draw_cycle(input int p, input bit se);
      int   ux, uy;
      bit   ep;
      pix_t got, want;
      ux = mx + (p % 4);
      uy = my + (p / 4);
      ep = se && vis(ux, uy);
      if (ep) sb_q.push_back('{x: 8'(ux), y: 7'(uy), c: 3'(mc)});
      chk("busy", busy, 1);
      chk("done", done, 0);
      chk("plot", plot, ep);
      chk("x_out", x_out, ux % 256);
      chk("y_out", y_out, uy % 128);
      chk("c_out", c_out, mc);
      if (plot) begin
         got = '{x: x_out, y: y_out, c: c_out};
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_plot: got pixel (%0d,%0d) expected none", x_out, y_out);
         end else begin
            want = sb_q.pop_front();
            chk("sb_pixel", got, want);
         end
      end
   endtask

   task automatic run_sweep(input vec_t v);
      int p, k;
      bit se;
      @(negedge clock);
      x_in = v.x; y_in = v.y; c_in = v.c;
      if (v.ld == 1) begin
         set_loads(1);
         @(negedge clock);
         set_loads(0);
      end
      if (v.ld == 0) set_loads(1);
      if (v.ld != 2) begin
         mx = v.x; my = v.y; mc = v.c;
      end
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      set_loads(0);
      p = 0;
      k = 1;
      while (p < 16 && k <= 100) begin
         case (v.mode)
            0:       se = 1'b1;
            1:       se = (k % 2 == 1);
            default: se = 1'($urandom_range(0, 1));
         endcase
         step_en = se;
         if (v.inject && k == 5) begin
            x_in = 8'd50;
            load_x = 1'b1;
            start = 1'b1;
         end
         #1;
         draw_cycle(p, se);
         if (se) p++;
         @(negedge clock);
         load_x = 1'b0;
         start = 1'b0;
         k++;
      end
      if (p < 16) chk("sweep_timeout_pixels", p, 16);
      step_en = 1'b1;
      #1;
      chk("done_pulse", done, 1);
      check_idle_outputs("done_state");
      @(negedge clock);
      #1;
      chk("done_after", done, 0);
      check_idle_outputs("idle_after");
      chk("sb_empty", sb_q.size(), 0);
   endtask

   vec_t tbl[8];

   initial begin
      tbl[0] = '{x: 8'd10,  y: 7'd20,  c: 3'd5, mode: 0, ld: 1, inject: 1'b0};
      tbl[1] = '{x: 8'd10,  y: 7'd20,  c: 3'd5, mode: 1, ld: 0, inject: 1'b0};
      tbl[2] = '{x: 8'd10,  y: 7'd20,  c: 3'd5, mode: 0, ld: 0, inject: 1'b1};
      tbl[3] = '{x: 8'd0,   y: 7'd0,   c: 3'd0, mode: 0, ld: 2, inject: 1'b0};
      tbl[4] = '{x: 8'd50,  y: 7'd20,  c: 3'd5, mode: 0, ld: 1, inject: 1'b0};
      tbl[5] = '{x: 8'd254, y: 7'd100, c: 3'd2, mode: 0, ld: 0, inject: 1'b0};
      tbl[6] = '{x: 8'd158, y: 7'd118, c: 3'd7, mode: 2, ld: 0, inject: 1'b0};
      tbl[7] = '{x: 8'd3,   y: 7'd126, c: 3'd6, mode: 1, ld: 0, inject: 1'b0};

      resetn = 1'b0;
      set_loads(0);
      x_in = '0; y_in = '0; c_in = '0;
      start = 1'b0;
      step_en = 1'b0;
      #1;
      chk("rst_done", done, 0);
      check_idle_outputs("rst");
      @(negedge clock);
      resetn = 1'b1;

      for (int i = 0; i < 8; i++) run_sweep(tbl[i]);

      // Reset asserted while pixel 7 is being presented
      @(negedge clock);
      x_in = 8'd10; y_in = 7'd20; c_in = 3'd5;
      set_loads(1);
      mx = 10; my = 20; mc = 5;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      set_loads(0);
      step_en = 1'b1;
      for (int p = 0; p < 7; p++) begin
         #1;
         draw_cycle(p, 1'b1);
         @(negedge clock);
      end
      #1;
      resetn = 1'b0;
      #1;
      mx = 0; my = 0; mc = 0;
      sb_q.delete();
      chk("midrst_done", done, 0);
      check_idle_outputs("midrst");
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      #1;
      chk("postrst_done", done, 0);
      check_idle_outputs("postrst");

      run_sweep(tbl[1]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
